booth_mul_pipe: RTL and testbench



---
 rtl/booth_mul_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_booth_mul_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_pipe.sv
// ---------------------------------------------------------------------------
// booth_mul_pipe
//   Pipelined radix-4 Booth multiplier with valid/ready handshakes on both
//   sides. The product is returned in issue order as two WIDTH-bit halves.
//
//   Optional feature: define MUL_FLUSH_EN to add the 'flush' input, which
//   discards every operation in flight.
//
// Parameters
//   WIDTH   operand width (even, >= 8)
//   STAGES  register slots from acceptance to output (1..4)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      (MUL_FLUSH_EN only) clear all slots, block input this cycle
//   in_valid   operands present          in_ready   operands accepted
//   A, B       multiplicand / multiplier mode       00 uu, 01 ss, 10 su, 11 uu
//   out_valid  product present           out_ready  consumer takes product
//   PROD_MSB   upper half of product     PROD_LSB   lower half of product
// ---------------------------------------------------------------------------
module booth_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUL_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] PROD_MSB,
    output logic [WIDTH-1:0] PROD_LSB
);

    localparam int PW    = 2 * WIDTH;      // product width
    localparam int XW    = WIDTH + 2;      // extended operand width
    localparam int NPP   = WIDTH / 2 + 1;  // Booth partial products
    localparam int NROWS = NPP + 1;        // plus one row of negation bits

    // Rows left after 'lvl' layers of 3:2 compression.
    function automatic int tree_rows(input int lvl);
        int n;
        n = NROWS;
        for (int i = 0; i < lvl; i++) begin
            if (n > 2) n = n - n / 3;
        end
        return n;
    endfunction

    function automatic int tree_levels();
        int n;
        int l;
        n = NROWS;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = n - n / 3;
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = tree_levels();

    genvar gi, gj;

    // ---------------- operand extension ----------------
    logic          w_a_sx, w_b_sx;
    logic [XW-1:0] w_ax, w_bx;
    logic [XW:0]   w_bx_l;     // extended B with the implicit b[-1] = 0 below
    logic [PW-1:0] w_ax_pw;    // extended A sign-extended to product width

    assign w_a_sx  = (mode == 2'b01) || (mode == 2'b10);
    assign w_b_sx  = (mode == 2'b01);
    assign w_ax    = {{2{w_a_sx & A[WIDTH-1]}}, A};
    assign w_bx    = {{2{w_b_sx & B[WIDTH-1]}}, B};
    assign w_bx_l  = {w_bx, 1'b0};
    assign w_ax_pw = {{(PW-XW){w_ax[XW-1]}}, w_ax};

    // ---------------- Booth recoding ----------------
    logic [PW-1:0] w_tree [0:LEVELS][0:NROWS-1];
    logic [NPP-1:0] w_neg;
    logic [PW-1:0]  w_corr;

    for (gi = 0; gi < NPP; gi++) begin : g_booth
        logic [2:0]    w_trip;
        logic          w_one, w_two;
        logic [PW-1:0] w_mag;
        assign w_trip    = w_bx_l[2*gi+2 -: 3];
        assign w_one     = w_trip[1] ^ w_trip[0];
        assign w_two     = (w_trip == 3'b100) || (w_trip == 3'b011);
        assign w_neg[gi] = w_trip[2] & ~(w_trip[1] & w_trip[0]);
        assign w_mag     = w_one ? w_ax_pw : (w_two ? {w_ax_pw[PW-2:0], 1'b0} : '0);
        // Negative digits use the one's complement here; the +1 lives in w_corr.
        assign w_tree[0][gi] = (w_neg[gi] ? ~w_mag : w_mag) << (2 * gi);
    end

    always_comb begin
        w_corr = '0;
        for (int j = 0; j < NPP; j++) begin
            w_corr[2*j] = w_neg[j];
        end
    end
    assign w_tree[0][NPP] = w_corr;

    // ---------------- carry-save tree ----------------
    for (gj = 0; gj < LEVELS; gj++) begin : g_lvl
        localparam int N_IN  = tree_rows(gj);
        localparam int G     = N_IN / 3;
        localparam int N_OUT = N_IN - G;
        for (gi = 0; gi < G; gi++) begin : g_csa
            logic [PW-1:0] w_x, w_y, w_z;
            assign w_x = w_tree[gj][3*gi];
            assign w_y = w_tree[gj][3*gi+1];
            assign w_z = w_tree[gj][3*gi+2];
            assign w_tree[gj+1][2*gi]   = w_x ^ w_y ^ w_z;
            assign w_tree[gj+1][2*gi+1] = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
        end
        for (gi = 0; gi < N_IN - 3*G; gi++) begin : g_pass
            assign w_tree[gj+1][2*G+gi] = w_tree[gj][3*G+gi];
        end
        for (gi = N_OUT; gi < NROWS; gi++) begin : g_zero
            assign w_tree[gj+1][gi] = '0;
        end
    end

    // ---------------- pipeline control ----------------
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_adv;
    logic              w_accept;

    // Slot k moves iff some slot at or after k is empty or the consumer takes
    // the head; written flat so no bit of w_adv depends on another.
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
        assign w_adv[gi] = out_ready | ~(&r_valid[STAGES-1:gi]);
    end

`ifdef MUL_FLUSH_EN
    assign in_ready = w_adv[0] & ~flush;
`else
    assign in_ready = w_adv[0];
`endif
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
`ifdef MUL_FLUSH_EN
            if (flush) begin
                r_valid <= '0;
            end else begin
`else
            begin
`endif
                if (w_adv[0]) r_valid[0] <= w_accept;
                for (int k = 1; k < STAGES; k++) begin
                    if (w_adv[k]) r_valid[k] <= r_valid[k-1];
                end
            end
        end
    end

    // ---------------- datapath registers (no reset needed) ----------------
    logic [PW-1:0] r_s0_sum, r_s0_carry;
    logic [PW-1:0] w_cpa;
    logic [PW-1:0] w_out_prod;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_sum   <= w_tree[LEVELS][0];
            r_s0_carry <= w_tree[LEVELS][1];
        end
    end

    assign w_cpa = r_s0_sum + r_s0_carry;

    if (STAGES == 1) begin : g_shallow
        assign w_out_prod = w_cpa;
    end else begin : g_deep
        logic [PW-1:0] r_prod [1:STAGES-1];
        always_ff @(posedge clk) begin
            if (w_adv[1] && r_valid[0]) r_prod[1] <= w_cpa;
            for (int k = 2; k < STAGES; k++) begin
                if (w_adv[k] && r_valid[k-1]) r_prod[k] <= r_prod[k-1];
            end
        end
        assign w_out_prod = r_prod[STAGES-1];
    end

    // ---------------- outputs ----------------
    // Gate data so stale, unreset data registers never reach the port.
    assign out_valid = r_valid[STAGES-1];
    assign {PROD_MSB, PROD_LSB} = out_valid ? w_out_prod : '0;

endmodule

// File: tb/tb_booth_mul_pipe.sv
module tb_booth_mul_pipe;

    localparam int W  = 32;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  PROD_MSB, PROD_LSB;

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];        // expected products of operations in flight
    logic [63:0] retired[$];  // products seen leaving, in order
    logic        held_valid = 1'b0;
    logic [63:0] held_prod = '0;
    logic        last_acc = 1'b0;
    logic        last_in_ready = 1'b1;

    booth_mul_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUL_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .PROD_MSB  (PROD_MSB),
        .PROD_LSB  (PROD_LSB)
    );

    always #5 clk = ~clk;

    // Exact product of the operands as interpreted by mode, modulo 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
        logic [63:0] ae, be;
        ae = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        be = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; sample handshakes, update
    // the model, then advance to 1 time unit after the next rising edge.
    task automatic cyc();
        logic [63:0] p;
        logic        exp_rdy;
        #1;
        p = {PROD_MSB, PROD_LSB};
        exp_rdy = !flush && ((q.size() < ST) || out_ready);
        check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
        last_in_ready = in_ready;
        if (held_valid) begin
            check("hold_valid", {63'b0, out_valid}, 64'd1);
            check("hold_data", p, held_prod);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", {63'b0, out_valid}, 64'd0);
            end else begin
                check("product", p, q.pop_front());
                retired.push_back(p);
                $display("retire prod=%h", p);
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) q.push_back(ref_mul(A, B, mode));
        held_valid = out_valid && !out_ready && !flush;
        held_prod  = p;
        if (flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] m, input logic [31:0] emsb, input logic [31:0] elsb);
        A = a; B = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
        cyc();
        check({tag, "_lat2"}, {63'b0, out_valid}, 64'd0);
        cyc();
        check({tag, "_lat3"}, {63'b0, out_valid}, 64'd1);
        check({tag, "_msb"}, {32'b0, PROD_MSB}, {32'b0, emsb});
        check({tag, "_lsb"}, {32'b0, PROD_LSB}, {32'b0, elsb});
        cyc();
        check({tag, "_one_cycle"}, {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] exp_stream [6];
        int          issued;
        logic        saw_stall;

        // ---- reset state ----
        #1;
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_prod", {PROD_MSB, PROD_LSB}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);

        // ---- directed arithmetic ----
        single_op("umax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 32'h0000_0001);
        single_op("signed", 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        single_op("mixed1", 32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        single_op("mixed2", 32'h0000_0002, 32'hFFFF_FFFF, 2'b10, 32'h0000_0001, 32'hFFFF_FFFE);
        single_op("mode11", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 32'h0000_0001);
        single_op("smin",   32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 32'h0000_0000);

        // ---- streaming with backpressure ----
        exp_stream = '{64'd0, 64'd2, 64'd6, 64'd12, 64'd20, 64'd30};
        retired.delete();
        issued = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c < 4) || (c >= 12);
            in_valid  = (issued < 6);
            A = issued;
            B = issued + 1;
            mode = 2'b00;
            cyc();
            if (last_acc) issued++;
            if (!last_in_ready) saw_stall = 1'b1;
        end
        in_valid = 1'b0;
        check("stream_in_ready_fell", {63'b0, saw_stall}, 64'd1);
        check("stream_count", 64'(retired.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < retired.size()) check("stream_order", retired[i], exp_stream[i]);
        end

        // ---- randomized traffic ----
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       A = 32'hFFFF_FFFF;
                1:       A = 32'h8000_0000;
                default: A = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       B = 32'hFFFF_FFFF;
                1:       B = 32'h8000_0000;
                default: B = $urandom;
            endcase
            mode = 2'($urandom_range(0, 3));
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        check("drain_empty", 64'(q.size()), 64'd0);

        // ---- reset mid-flight ----
        out_ready = 1'b0;
        mode = 2'b00;
        in_valid = 1'b1; A = 5; B = 6;
        cyc();
        A = 7; B = 8;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("pre_reset_valid", {63'b0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_prod", {PROD_MSB, PROD_LSB}, 64'd0);
        q.delete();
        held_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("midrst_no_stale", {63'b0, out_valid}, 64'd0);
        end

`ifdef MUL_FLUSH_EN
        // ---- flush ----
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; A = i + 3; B = i + 4; mode = 2'b00;
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {63'b0, out_valid}, 64'd0);
        single_op("post_flush", 32'd7, 32'd9, 2'b00, 32'd0, 32'd63);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
